// File: rtl/vortex_dcr_receiver.sv
// Vortex-side DCR write endpoint: accepts one buffered message, range-checks
// it, waits out vx_busy, then pulses the Vortex DCR write port.
module vortex_dcr_receiver #(
    parameter int VX_DCR_ADDR_WIDTH = 8,
    parameter int VX_DCR_DATA_WIDTH = 32,
    parameter logic [VX_DCR_ADDR_WIDTH-1:0] ADDR_MIN = 8'h01,
    parameter logic [VX_DCR_ADDR_WIDTH-1:0] ADDR_MAX = 8'h3F,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [VX_DCR_ADDR_WIDTH-1:0] in_addr,
    input  logic [VX_DCR_DATA_WIDTH-1:0] in_data,
    output logic                         in_rdy,
    input  logic                         vx_busy,
    output logic                         dcr_wr_valid,
    output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0] dcr_wr_data,
    output logic [CNT_WIDTH-1:0]         wr_count,
    output logic                         drop_err,
    input  logic                         err_clr
);

    typedef enum logic [1:0] {IDLE, PEND, ISSUE, GAP} state_t;

    localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

    state_t                         state_q, state_d;
    logic [VX_DCR_ADDR_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic [VX_DCR_DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [VX_DCR_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [VX_DCR_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [CNT_WIDTH-1:0]           wr_count_q, wr_count_d;
    logic                           drop_err_q, drop_err_d;
    logic [3:0]                     gap_q, gap_d;
    logic                           drop_set;
    logic                           addr_ok;

    assign addr_ok = (hold_addr_q >= ADDR_MIN) && (hold_addr_q <= ADDR_MAX);

    // Gated by rst so the sender never sees ready during reset.
    assign in_rdy = (state_q == IDLE) && !vx_busy && !rst;

    always_comb begin
        state_d     = state_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_count_d  = wr_count_q;
        gap_d       = gap_q;
        drop_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_rdy) begin
                    hold_addr_d = in_addr;
                    hold_data_d = in_data;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (!addr_ok) begin
                    drop_set = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LD;
                    end
                end else if (!vx_busy) begin
                    state_d    = ISSUE;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = hold_addr_q;
                    wr_data_d  = hold_data_q;
                    wr_count_d = wr_count_q + 1'b1;
                end
            end
            ISSUE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LD;
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new drop in the same cycle as a clear keeps the flag set.
        drop_err_d = drop_set | (drop_err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_count_q  <= '0;
            drop_err_q  <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_count_q  <= wr_count_d;
            drop_err_q  <= drop_err_d;
            gap_q       <= gap_d;
        end
    end

    assign dcr_wr_valid = wr_valid_q;
    assign dcr_wr_addr  = wr_addr_q;
    assign dcr_wr_data  = wr_data_q;
    assign wr_count     = wr_count_q;
    assign drop_err     = drop_err_q;

endmodule

// File: tb/tb_vortex_dcr_receiver.sv
// Directed bench for vortex_dcr_receiver; a second narrow-counter
// instance shares the stimulus to reach the counter wrap quickly.
module tb_vortex_dcr_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        vx_busy = 1'b0;
    logic        err_clr = 1'b0;

    logic        in_rdy, dcr_wr_valid, drop_err;
    logic [7:0]  dcr_wr_addr;
    logic [31:0] dcr_wr_data;
    logic [15:0] wr_count;

    logic        in_rdy_w, dcr_wr_valid_w, drop_err_w;
    logic [7:0]  dcr_wr_addr_w;
    logic [31:0] dcr_wr_data_w;
    logic [2:0]  wr_count_w;

    int passed = 0;
    int total = 0;
    int exp_cnt = 0;

    vortex_dcr_receiver dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr),
        .in_data(in_data), .in_rdy(in_rdy),
        .vx_busy(vx_busy),
        .dcr_wr_valid(dcr_wr_valid),
        .dcr_wr_addr(dcr_wr_addr),
        .dcr_wr_data(dcr_wr_data),
        .wr_count(wr_count),
        .drop_err(drop_err), .err_clr(err_clr)
    );

    vortex_dcr_receiver #(.CNT_WIDTH(3)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr),
        .in_data(in_data), .in_rdy(in_rdy_w),
        .vx_busy(vx_busy),
        .dcr_wr_valid(dcr_wr_valid_w),
        .dcr_wr_addr(dcr_wr_addr_w),
        .dcr_wr_data(dcr_wr_data_w),
        .wr_count(wr_count_w),
        .drop_err(drop_err_w), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_rdy && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (in_rdy !== 1'b1)
            $display("FAIL wait_idle: in_rdy=%b want 1", in_rdy);
        else passed++;
    endtask

    task automatic accept(input logic [7:0] a, input logic [31:0] d);
        wait_idle();
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        while (!dcr_wr_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++;
        if ({dcr_wr_valid, dcr_wr_addr, dcr_wr_data} !== '0)
            $display("FAIL rst_wr: got %b/%h/%h want 0",
                     dcr_wr_valid, dcr_wr_addr, dcr_wr_data);
        else passed++;
        total++;
        if ({in_rdy, drop_err, wr_count} !== '0)
            $display("FAIL rst_ctl: rdy=%b err=%b cnt=%h want 0",
                     in_rdy, drop_err, wr_count);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1)
            $display("FAIL rst_rel_rdy: got %b want 1", in_rdy);
        else passed++;
    endtask

    task automatic test_single();
        wait_idle();
        in_valid = 1'b1;
        in_addr  = 8'h01;
        in_data  = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        total++;
        if ({in_rdy, dcr_wr_valid} !== 2'b00)
            $display("FAIL single_n1: rdy=%b v=%b want 0/0",
                     in_rdy, dcr_wr_valid);
        else passed++;
        tick();
        exp_cnt++;
        total++;
        if (dcr_wr_valid !== 1'b1 || dcr_wr_addr !== 8'h01 ||
            dcr_wr_data !== 32'hDEADBEEF || in_rdy !== 1'b0)
            $display("FAIL single_n2: v=%b a=%h d=%h rdy=%b want 1/01/deadbeef/0",
                     dcr_wr_valid, dcr_wr_addr, dcr_wr_data, in_rdy);
        else passed++;
        tick();
        total++;
        if ({in_rdy, dcr_wr_valid} !== 2'b00 || dcr_wr_addr !== 8'h01)
            $display("FAIL single_n3: rdy=%b v=%b a=%h want 0/0/01",
                     in_rdy, dcr_wr_valid, dcr_wr_addr);
        else passed++;
        tick();
        total++;
        if (in_rdy !== 1'b0)
            $display("FAIL single_n4: rdy=%b want 0", in_rdy);
        else passed++;
        tick();
        total++;
        if (in_rdy !== 1'b1 || wr_count !== 16'(exp_cnt))
            $display("FAIL single_n5: rdy=%b cnt=%0d want 1/%0d",
                     in_rdy, wr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int pcyc[8];
        logic [7:0] paddr[8];
        logic [31:0] pdata[8];
        int np = 0;
        int sent = 0;
        logic acc;
        wait_idle();
        in_valid = 1'b1;
        in_addr  = 8'h01;
        in_data  = 32'hC0FFEE01;
        for (int c = 0; c < 50; c++) begin
            if (dcr_wr_valid) begin
                if (np < 8) begin
                    pcyc[np]  = c;
                    paddr[np] = dcr_wr_addr;
                    pdata[np] = dcr_wr_data;
                end
                np++;
            end
            acc = in_valid && in_rdy;
            tick();
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    in_addr = 8'(sent + 1);
                    in_data = 32'hC0FFEE00 | 32'(sent + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        exp_cnt += 8;
        total++;
        if (np !== 8)
            $display("FAIL b2b_count: pulses=%0d want 8", np);
        else passed++;
        if (np == 8) begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (paddr[i] !== 8'(i + 1) ||
                    pdata[i] !== (32'hC0FFEE00 | 32'(i + 1)))
                    $display("FAIL b2b_msg%0d: a=%h d=%h want %h/%h",
                             i, paddr[i], pdata[i], 8'(i + 1),
                             32'hC0FFEE00 | 32'(i + 1));
                else passed++;
                if (i > 0) begin
                    total++;
                    if (pcyc[i] - pcyc[i-1] != 5)
                        $display("FAIL b2b_gap%0d: got %0d want 5",
                                 i, pcyc[i] - pcyc[i-1]);
                    else passed++;
                end
            end
        end
        total++;
        if (wr_count !== 16'(exp_cnt))
            $display("FAIL b2b_wrcnt: got %0d want %0d", wr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_drop();
        int n;
        accept(8'h40, 32'h11111111);
        total++;
        if ({drop_err, dcr_wr_valid} !== 2'b00)
            $display("FAIL drop_n1: err=%b v=%b want 0/0",
                     drop_err, dcr_wr_valid);
        else passed++;
        tick();
        total++;
        if ({drop_err, dcr_wr_valid} !== 2'b10)
            $display("FAIL drop_n2: err=%b v=%b want 1/0",
                     drop_err, dcr_wr_valid);
        else passed++;
        tick();
        total++;
        if (in_rdy !== 1'b0 || dcr_wr_valid !== 1'b0)
            $display("FAIL drop_n3: rdy=%b v=%b want 0/0",
                     in_rdy, dcr_wr_valid);
        else passed++;
        tick();
        total++;
        if (in_rdy !== 1'b1 || wr_count !== 16'(exp_cnt) ||
            dcr_wr_addr !== 8'h08)
            $display("FAIL drop_n4: rdy=%b cnt=%0d a=%h want 1/%0d/08",
                     in_rdy, wr_count, dcr_wr_addr, exp_cnt);
        else passed++;
        accept(8'h3F, 32'h3F3F0000);
        wait_pulse(n);
        exp_cnt++;
        total++;
        if (n != 1 || dcr_wr_addr !== 8'h3F ||
            dcr_wr_data !== 32'h3F3F0000 || drop_err !== 1'b1)
            $display("FAIL drop_legal: lat=%0d a=%h d=%h err=%b want 1/3f/3f3f0000/1",
                     n, dcr_wr_addr, dcr_wr_data, drop_err);
        else passed++;
        accept(8'h00, 32'h22220000);
        err_clr = 1'b1;
        tick();
        total++;
        if (drop_err !== 1'b1)
            $display("FAIL drop_setwins: err=%b want 1", drop_err);
        else passed++;
        tick();
        err_clr = 1'b0;
        total++;
        if (drop_err !== 1'b0 || wr_count !== 16'(exp_cnt))
            $display("FAIL drop_clr: err=%b cnt=%0d want 0/%0d",
                     drop_err, wr_count, exp_cnt);
        else passed++;
    endtask

    task automatic test_busy();
        logic bad = 1'b0;
        wait_idle();
        vx_busy  = 1'b1;
        in_valid = 1'b1;
        in_addr  = 8'h22;
        in_data  = 32'h22222222;
        #1;
        total++;
        if (in_rdy !== 1'b0)
            $display("FAIL busy_idle_rdy: got %b want 0", in_rdy);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dcr_wr_valid || in_rdy) bad = 1'b1;
        end
        total++;
        if (bad !== 1'b0 || wr_count !== 16'(exp_cnt))
            $display("FAIL busy_idle_hold: bad=%b cnt=%0d want 0/%0d",
                     bad, wr_count, exp_cnt);
        else passed++;
        vx_busy = 1'b0;
        #1;
        total++;
        if (in_rdy !== 1'b1)
            $display("FAIL busy_release_rdy: got %b want 1", in_rdy);
        else passed++;
        tick();
        in_valid = 1'b0;
        vx_busy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (dcr_wr_valid) bad = 1'b1;
            tick();
        end
        vx_busy = 1'b0;
        total++;
        if (bad !== 1'b0 || dcr_wr_valid !== 1'b0)
            $display("FAIL busy_pend_stall: bad=%b v=%b want 0/0",
                     bad, dcr_wr_valid);
        else passed++;
        tick();
        exp_cnt++;
        total++;
        if (dcr_wr_valid !== 1'b1 || dcr_wr_addr !== 8'h22 ||
            dcr_wr_data !== 32'h22222222)
            $display("FAIL busy_pend_issue: v=%b a=%h d=%h want 1/22/22222222",
                     dcr_wr_valid, dcr_wr_addr, dcr_wr_data);
        else passed++;
    endtask

    task automatic test_reset_pend();
        logic bad = 1'b0;
        accept(8'h05, 32'h55555555);
        rst = 1'b1;
        #1;
        total++;
        if ({dcr_wr_valid, dcr_wr_addr, dcr_wr_data, wr_count,
             in_rdy, drop_err} !== '0)
            $display("FAIL rstpend_out: v=%b a=%h d=%h cnt=%0d rdy=%b err=%b want 0",
                     dcr_wr_valid, dcr_wr_addr, dcr_wr_data, wr_count,
                     in_rdy, drop_err);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dcr_wr_valid) bad = 1'b1;
        end
        total++;
        if (bad !== 1'b0 || wr_count !== 16'd0 || in_rdy !== 1'b1)
            $display("FAIL rstpend_after: bad=%b cnt=%0d rdy=%b want 0/0/1",
                     bad, wr_count, in_rdy);
        else passed++;
    endtask

    task automatic test_wrap();
        int n;
        for (int i = 1; i <= 8; i++) begin
            accept(8'(i), 32'(i));
            wait_pulse(n);
            exp_cnt++;
            total++;
            if (n != 1 || dcr_wr_addr !== 8'(i))
                $display("FAIL wrap_issue%0d: lat=%0d a=%h want 1/%h",
                         i, n, dcr_wr_addr, 8'(i));
            else passed++;
            if (i == 7) begin
                total++;
                if (wr_count_w !== 3'd7)
                    $display("FAIL wrap_allones: got %0d want 7", wr_count_w);
                else passed++;
            end
        end
        total++;
        if (wr_count_w !== 3'd0 || wr_count !== 16'd8)
            $display("FAIL wrap_zero: narrow=%0d wide=%0d want 0/8",
                     wr_count_w, wr_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_busy();
        test_reset_pend();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vortex_dcr_receiver.md
Name: vortex_dcr_receiver

Overview:
- Vortex-side endpoint of the DCR write channel driven by the chipset DCR buffer.
- Accepts one buffered DCR message per valid/ready handshake and range-checks the address.
- Holds the message while Vortex is busy, then issues it as a single-cycle write pulse on the Vortex DCR write port.
- Enforces a minimum idle gap between successive writes and keeps a write counter and a sticky drop-error flag for core control.

Parameters:
- VX_DCR_ADDR_WIDTH, 8, DCR address width.
- VX_DCR_DATA_WIDTH, 32, DCR data width.
- ADDR_MIN, 8'h01, lowest legal DCR address (inclusive).
- ADDR_MAX, 8'h3F, highest legal DCR address (inclusive).
- GAP_CYCLES, 2, idle cycles after each issue or drop before in_rdy can reassert. Range 0..15.
- CNT_WIDTH, 16, width of wr_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  message valid from the DCR buffer.
- in_addr  in  VX_DCR_ADDR_WIDTH  message address.
- in_data  in  VX_DCR_DATA_WIDTH  message data.
- in_rdy  out  1  receiver ready. A transfer occurs only on a cycle where in_valid && in_rdy.
- vx_busy  in  1  Vortex running. DCR writes are forbidden while high.
- dcr_wr_valid  out  1  one-cycle Vortex DCR write strobe.
- dcr_wr_addr  out  VX_DCR_ADDR_WIDTH  write address, registered.
- dcr_wr_data  out  VX_DCR_DATA_WIDTH  write data, registered.
- wr_count  out  CNT_WIDTH  count of issued writes.
- drop_err  out  1  sticky flag: an out-of-range message was dropped.
- err_clr  in  1  clears drop_err.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE.
  - in_rdy=0 while rst is high.
  - dcr_wr_valid=0, dcr_wr_addr=0, dcr_wr_data=0.
  - wr_count=0, drop_err=0, gap counter=0.
- Reset mid-operation discards any captured message; no write pulse is emitted for it.
- in_rdy = (state==IDLE) && !vx_busy. It is combinational from registered state plus vx_busy; the sender registers ready on its side.
- IDLE:
  - On in_valid && in_rdy, latch in_addr/in_data into a holding register and go to PEND.
  - Otherwise stay in IDLE.
- PEND (in_rdy=0):
  - If the held address is < ADDR_MIN or > ADDR_MAX: set drop_err, go to GAP. No write is issued.
  - Else if vx_busy: stay in PEND. The range check is re-evaluated each cycle, with the same result.
  - Else: go to ISSUE.
- ISSUE (exactly one cycle):
  - dcr_wr_valid=1; dcr_wr_addr/dcr_wr_data show the held message.
  - wr_count increments and wraps from all-ones to 0.
  - Go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP:
  - Gap counter loads GAP_CYCLES on entry and decrements each cycle.
  - Return to IDLE the cycle after it reaches 1, so there are exactly GAP_CYCLES cycles in GAP.
  - For a drop with GAP_CYCLES==0, PEND goes directly to IDLE.
- dcr_wr_addr/dcr_wr_data keep their last issued value outside ISSUE. dcr_wr_valid is 0 in every state except ISSUE.
- Latency: accept at cycle N → PEND at N+1 → dcr_wr_valid at N+2 (with vx_busy low).
- Minimum spacing between accepts: 3+GAP_CYCLES cycles.
- vx_busy:
  - Rising in IDLE blocks acceptance the same cycle.
  - Rising in ISSUE or GAP does not cancel the write already committed.
  - Rising in PEND stalls the issue until vx_busy falls.
- in_valid without in_rdy is ignored; nothing is captured.
- drop_err: if set and err_clr occur in the same cycle, set wins.
- Only one message is ever held; there is no internal queue. Backpressure is entirely via in_rdy.

Test Plan:
- Reset, GAP_CYCLES=2, vx_busy=0; in_valid with addr 0x01, data 0xDEADBEEF accepted at cycle N → dcr_wr_valid=1 only at N+2 with 0x01/0xDEADBEEF; in_rdy=0 N+1..N+4, 1 at N+5; wr_count=1.
- Hold in_valid high with 8 messages, addrs 0x01..0x08 → 8 pulses exactly 5 cycles apart, in order, data intact; wr_count=8.
- Accept addr 0x40 → no dcr_wr_valid; drop_err=1 from N+2; wr_count unchanged; next legal message 0x3F issues normally. err_clr asserted together with a new drop leaves drop_err=1.
- vx_busy=1 in IDLE → in_rdy=0, nothing accepted. Message accepted, then vx_busy=1 at N+1 for 10 cycles → pulse occurs 1 cycle after vx_busy falls.
- Assert rst in PEND → all outputs 0 immediately; no pulse for the held message after release; wr_count=0.
- Preload wr_count to 0xFFFF via 65535 writes (or force) → next issue yields 0x0000.
